rf_write_queue: RTL

//  Write-side front end of the register file. Collects write requests from the ALU and load unit,

---
 rtl/mips_pkg.sv | 17 +
 rtl/wb_fifo.sv | 96 +++++++++
 rtl/rf_write_queue.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the register-file write path.
// The register file and the decode stage import the same package, so all
// three agree on the register index width, data width and zero register.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  // One pending register-file write.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order write-back FIFO: storage, read/write pointers, occupancy count and
// full/empty flags. The storage and the read pointer are exported so that the
// parent can search the queue for bypass data.
//
// Ports
//   clk, rst_n       clock, async active-low reset
//   push_i           enqueue push_reg_i/push_data_i (ignored when full)
//   pop_i            dequeue the head entry (ignored when empty)
//   head_reg_o/data  head entry
//   rd_ptr_o         slot index of the head (oldest) entry
//   cnt_o            valid entries held, 0..DEPTH
//   full_o, empty_o  occupancy flags
//   ent_reg_o/data_o raw slot contents, indexed by slot
module wb_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_reg_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [ADDR_W-1:0] head_reg_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic [PTR_W-1:0]  rd_ptr_o,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W-1:0] ent_reg_o  [DEPTH],
  output logic [DATA_W-1:0] ent_data_o [DEPTH]
);

  logic [ADDR_W-1:0] reg_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);

  // Guards make over/underflow impossible regardless of what the parent asks.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    // DEPTH is a power of two, so pointer increments wrap naturally.
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        reg_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (do_push) begin
      reg_q[wr_ptr_q]  <= push_reg_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_reg_o  = reg_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];
  assign rd_ptr_o    = rd_ptr_q;
  assign cnt_o       = cnt_q;
  assign ent_reg_o   = reg_q;
  assign ent_data_o  = data_q;

endmodule

// File: rtl/rf_write_queue.sv
// Write-side front end of the register file.
// Accepts write requests from the load unit (priority) and the ALU, drops
// writes to the zero register, buffers the rest in order and presents the
// head entry on the RF write port whenever the port is granted. Decode can
// look up pending writes through two combinational bypass ports.
//
// Ports
//   clk, reset                     clock, async active-low reset
//   alu_valid/reg/data, alu_ready  ALU write request handshake
//   mem_valid/reg/data, mem_ready  load write request handshake
//   rf_grant                       RF write port free this cycle
//   rf_write_reg/data, rf_reg_write  RF write port
//   byp_reg1/2                     decode read indices
//   byp_hit1/2, byp_data1/2        youngest pending write for each index
//   pending_cnt                    entries held
module rf_write_queue
  import mips_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = REG_ADDR_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              rf_grant,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_reg_write,
  input  logic [ADDR_W-1:0] byp_reg1,
  input  logic [ADDR_W-1:0] byp_reg2,
  output logic              byp_hit1,
  output logic              byp_hit2,
  output logic [DATA_W-1:0] byp_data1,
  output logic [DATA_W-1:0] byp_data2,
  output logic [CNT_W-1:0]  pending_cnt
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic              full, empty;
  logic              mem_take, alu_take;
  logic              push;
  logic [ADDR_W-1:0] push_reg;
  logic [DATA_W-1:0] push_data;
  logic [ADDR_W-1:0] head_reg;
  logic [DATA_W-1:0] head_data;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] ent_reg  [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];

  // Full is the registered occupancy, so a pop in the same cycle cannot
  // free a slot for an enqueue.
  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;

  assign mem_take  = mem_valid && mem_ready;
  assign alu_take  = alu_valid && alu_ready;
  assign push_reg  = mem_valid ? mem_reg  : alu_reg;
  assign push_data = mem_valid ? mem_data : alu_data;

  // Zero-register writes finish the handshake but never occupy a slot.
  assign push = (mem_take || alu_take) && (push_reg != ZERO_IDX);

  assign rf_reg_write  = !empty && rf_grant;
  assign rf_write_reg  = empty ? '0 : head_reg;
  assign rf_write_data = empty ? '0 : head_data;
  assign pending_cnt   = cnt;

  wb_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .push_i      (push),
    .push_reg_i  (push_reg),
    .push_data_i (push_data),
    .pop_i       (rf_reg_write),
    .head_reg_o  (head_reg),
    .head_data_o (head_data),
    .rd_ptr_o    (rd_ptr),
    .cnt_o       (cnt),
    .full_o      (full),
    .empty_o     (empty),
    .ent_reg_o   (ent_reg),
    .ent_data_o  (ent_data)
  );

  // Walk from oldest to youngest; a later match overrides an earlier one,
  // so the surviving data is from the youngest matching entry.
  always_comb begin
    logic [PTR_W-1:0] idx;
    byp_hit1  = 1'b0;
    byp_hit2  = 1'b0;
    byp_data1 = '0;
    byp_data2 = '0;
    idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if (CNT_W'(k) < cnt) begin
        if ((byp_reg1 != ZERO_IDX) && (ent_reg[idx] == byp_reg1)) begin
          byp_hit1  = 1'b1;
          byp_data1 = ent_data[idx];
        end
        if ((byp_reg2 != ZERO_IDX) && (ent_reg[idx] == byp_reg2)) begin
          byp_hit2  = 1'b1;
          byp_data2 = ent_data[idx];
        end
      end
    end
  end

endmodule
